mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MUL_LAT, default 4, MULT execute cycles in MULW; legal range 1..15.
REQ-002 Parameter EN_MULT, default 1; 1 = MULT (R-type funct 011000) supported, 0 = MULT treated as illegal.
REQ-003 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; both valid from DECODE onward.
REQ-007 zero  in  1  ALU zero flag, sampled in EXEC.
REQ-008 mem_ready  in  1  memory completion strobe for the current mem_rd/mem_wr request.
REQ-009 pc_wr, ir_wr, wr_en, mem_rd, mem_wr, hilo_wr  out  1  write/request strobes.
REQ-010 sel_dest [1:0], sel_opB [0], alu_op [5:0], sel_data [1:0], sel_pc [1:0]  out  datapath selects; codes: sel_dest 0 rd/1 rt/2 r31; sel_data 0 ALU/1 mem/2 PC; sel_pc 0 PC+4/1 branch/2 jump/3 rs.
REQ-011 sel_addr  out  1  0 = PC addresses memory, 1 = ALU result addresses memory.
REQ-012 state  out  3  current state; illegal  out  1  one-cycle pulse; retired  out  CNT_W  instruction count.

Function
REQ-013 Controller SHALL be a Moore/Mealy FSM, states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULW=5; codes 6,7 SHALL go to FETCH next cycle.
REQ-014 FETCH: mem_rd=1, sel_addr=0; hold while mem_ready=0; on mem_ready=1 assert ir_wr=1, pc_wr=1, sel_pc=0 that cycle -> DECODE.
REQ-015 DECODE (1 cycle): J -> pc_wr=1, sel_pc=2 -> FETCH; JAL -> pc_wr=1, sel_pc=2, wr_en=1, sel_dest=2, sel_data=2 -> FETCH; unsupported opcode/funct -> illegal=1 -> FETCH; otherwise -> EXEC.
REQ-016 Supported set: R-type ADD 100000, SUB 100010, SLT 101010, SLL 000000, SRL 000010, JR 001000, MULT 011000 (if EN_MULT); ADDI 001000, SLTI 001010, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011.
REQ-017 EXEC alu_op/sel_opB: R-type alu_op=funct, sel_opB=0; ADDI/LW/SW alu_op=100000, sel_opB=1; SLTI alu_op=101010, sel_opB=1; BEQ/BNE alu_op=opcode, sel_opB=0.
REQ-018 EXEC transitions: ALU R-type/ADDI/SLTI -> WB; LW/SW -> MEM; BEQ -> pc_wr=zero, sel_pc=1 -> FETCH; BNE -> pc_wr=!zero, sel_pc=1 -> FETCH; JR -> pc_wr=1, sel_pc=3 -> FETCH; MULT -> MULW.
REQ-019 MULW: alu_op=011000 held; 4-bit counter from 0; hilo_wr=1 in cycle MUL_LAT-1 (MUL_LAT=1: first MULW cycle), then -> FETCH.
REQ-020 MEM: sel_addr=1; LW mem_rd=1, SW mem_wr=1, held until mem_ready=1; LW -> WB, SW -> FETCH; mem_ready outside FETCH/MEM SHALL be ignored.
REQ-021 WB (1 cycle): wr_en=1; R-type sel_dest=0, sel_data=0; ADDI/SLTI sel_dest=1, sel_data=0; LW sel_dest=1, sel_data=1 -> FETCH.
REQ-022 All strobes not explicitly asserted in a state SHALL be 0; selects default 0; at most one of mem_rd/mem_wr high per cycle.
REQ-023 retired SHALL increment by 1 on every transition into FETCH from DECODE/EXEC/MEM/WB/MULW, except illegal instructions; wraps modulo 2^CNT_W.
REQ-024 Instruction latency (mem_ready immediate): J/JAL 2, BEQ/BNE/JR 3, SW 4, R-type/ADDI/SLTI 4, LW 5, MULT 3+MUL_LAT cycles.

Reset
REQ-025 rst=1 SHALL immediately force state=FETCH, all strobes 0, selects 0, MULW counter 0, retired 0, illegal 0.
REQ-026 Reset asserted mid-instruction SHALL abort it with no pc_wr/wr_en/mem_wr/hilo_wr after assertion; after deassertion, first cycle is FETCH with mem_rd=1.

Verification
REQ-027 ADD (op 0, funct 100000), mem_ready always 1 -> states 0,1,2,4,0; wr_en=1 only in WB with sel_dest=0; retired 0->1.
REQ-028 LW with mem_ready held 0 for 3 MEM cycles -> mem_rd=1, sel_addr=1 for 4 cycles, then WB with sel_data=1, sel_dest=1.
REQ-029 BEQ zero=0 then BNE zero=0 -> first pc_wr=0 in EXEC, second pc_wr=1 with sel_pc=1; retired +2.
REQ-030 MULT, MUL_LAT=4 -> MULW 4 cycles, hilo_wr=1 only in 4th; with EN_MULT=0 same instruction -> illegal pulse in DECODE, retired unchanged.
REQ-031 JAL -> DECODE cycle pc_wr=1, sel_pc=2, wr_en=1, sel_dest=2, sel_data=2; opcode 111111 -> illegal=1 one cycle, back to FETCH.
REQ-032 rst pulse during SW MEM wait -> mem_wr drops to 0 at once, state=0, retired=0; retired wraps 2^CNT_W-1 -> 0 with CNT_W=4 after 16 instructions.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: control FSM for a multi-cycle MIPS-subset datapath.
// The state register and the counters are clocked. The strobes and selects are decoded from
// the current state, the held IR fields, zero and mem_ready. They are forced low while rst
// is high, so an abort takes effect before the next clock edge.
module mc_controller #(
    parameter int unsigned MUL_LAT = 4,   // MULW cycles, 1..15
    parameter int unsigned EN_MULT = 1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             wr_en,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             hilo_wr,
    output logic [1:0]       sel_dest,
    output logic             sel_opB,
    output logic [5:0]       alu_op,
    output logic [1:0]       sel_data,
    output logic [1:0]       sel_pc,
    output logic             sel_addr,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StMulw   = 3'd5
    } state_e;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FnSll   = 6'b000000;
    localparam logic [5:0] FnSrl   = 6'b000010;
    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnAdd   = 6'b100000;
    localparam logic [5:0] FnSub   = 6'b100010;
    localparam logic [5:0] FnSlt   = 6'b101010;

    // Last MULW cycle index; the result is written to HI/LO in that cycle
    localparam logic [3:0] MulLast = 4'(MUL_LAT - 1);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       mul_cnt_q;
    logic [CNT_W-1:0] retired_q;

    logic is_r;
    logic r_alu;
    logic r_jr;
    logic r_mult;
    logic is_addi;
    logic is_slti;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic is_jal;
    logic legal;

    // Decode the instruction class from the IR fields, which stay stable after FETCH
    always_comb begin
        is_r    = (opcode == OpRtype);
        r_alu   = is_r && ((funct == FnAdd) || (funct == FnSub) || (funct == FnSlt) ||
                           (funct == FnSll) || (funct == FnSrl));
        r_jr    = is_r && (funct == FnJr);
        r_mult  = is_r && (funct == FnMult) && (EN_MULT != 0);
        is_addi = (opcode == OpAddi);
        is_slti = (opcode == OpSlti);
        is_lw   = (opcode == OpLw);
        is_sw   = (opcode == OpSw);
        is_beq  = (opcode == OpBeq);
        is_bne  = (opcode == OpBne);
        is_j    = (opcode == OpJ);
        is_jal  = (opcode == OpJal);
        legal   = r_alu || r_jr || r_mult || is_addi || is_slti || is_lw || is_sw ||
                  is_beq || is_bne || is_j || is_jal;
    end

    // Next state and datapath controls; every output stays at 0 while rst is high
    always_comb begin
        state_d  = state_q;
        pc_wr    = 1'b0;
        ir_wr    = 1'b0;
        wr_en    = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        hilo_wr  = 1'b0;
        illegal  = 1'b0;
        sel_dest = 2'd0;
        sel_opB  = 1'b0;
        alu_op   = 6'd0;
        sel_data = 2'd0;
        sel_pc   = 2'd0;
        sel_addr = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_wr   = 1'b1;
                        pc_wr   = 1'b1;
                        state_d = StDecode;
                    end
                end
                StDecode: begin
                    if (!legal) begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end else if (is_j) begin
                        pc_wr   = 1'b1;
                        sel_pc  = 2'd2;
                        state_d = StFetch;
                    end else if (is_jal) begin
                        // Link: r31 <= PC (already PC+4 after FETCH)
                        pc_wr    = 1'b1;
                        sel_pc   = 2'd2;
                        wr_en    = 1'b1;
                        sel_dest = 2'd2;
                        sel_data = 2'd2;
                        state_d  = StFetch;
                    end else begin
                        state_d = StExec;
                    end
                end
                StExec: begin
                    if (is_r) begin
                        alu_op = funct;
                    end else if (is_addi || is_lw || is_sw) begin
                        alu_op  = FnAdd;
                        sel_opB = 1'b1;
                    end else if (is_slti) begin
                        alu_op  = FnSlt;
                        sel_opB = 1'b1;
                    end else if (is_beq || is_bne) begin
                        alu_op = opcode;
                    end

                    if (r_alu || is_addi || is_slti) begin
                        state_d = StWb;
                    end else if (is_lw || is_sw) begin
                        state_d = StMem;
                    end else if (is_beq) begin
                        pc_wr   = zero;
                        sel_pc  = 2'd1;
                        state_d = StFetch;
                    end else if (is_bne) begin
                        pc_wr   = !zero;
                        sel_pc  = 2'd1;
                        state_d = StFetch;
                    end else if (r_jr) begin
                        pc_wr   = 1'b1;
                        sel_pc  = 2'd3;
                        state_d = StFetch;
                    end else if (r_mult) begin
                        state_d = StMulw;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StMem: begin
                    sel_addr = 1'b1;
                    mem_rd   = is_lw;
                    mem_wr   = is_sw;
                    // A non-memory IR here cannot complete, so it is dropped
                    if (!(is_lw || is_sw)) begin
                        state_d = StFetch;
                    end else if (mem_ready) begin
                        state_d = is_lw ? StWb : StFetch;
                    end
                end
                StWb: begin
                    wr_en    = 1'b1;
                    sel_dest = is_r ? 2'd0 : 2'd1;
                    sel_data = is_lw ? 2'd1 : 2'd0;
                    state_d  = StFetch;
                end
                StMulw: begin
                    alu_op = FnMult;
                    if (mul_cnt_q == MulLast) begin
                        hilo_wr = 1'b1;
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end
    end

    // State register, MULW cycle counter and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            mul_cnt_q <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == StMulw) && (state_d == StMulw)) begin
                mul_cnt_q <= mul_cnt_q + 4'd1;
            end else begin
                mul_cnt_q <= 4'd0;
            end
            // Count completed instructions; illegal ones return to FETCH uncounted
            if ((state_q != StFetch) && (state_d == StFetch) && !illegal) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. Three instances with different
// parameters share the stimulus, and the bench compares only the selected one.
module tb_mc_controller;

    // Observed/expected output bundle; stb = {pc_wr, ir_wr, wr_en, mem_rd, mem_wr, hilo_wr, illegal}
    typedef struct packed {
        logic [2:0] st;
        logic [6:0] stb;
        logic [1:0] pc;
        logic [1:0] dst;
        logic [1:0] dat;
        logic       addr;
        logic [5:0] alu;
        logic       opb;
    } out_t;

    // One scoreboard entry per clock cycle: mem_ready to drive, outputs expected
    typedef struct packed {
        logic mr;
        out_t o;
    } ent_t;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    out_t        o_out [3];
    logic [31:0] o_ret [3];
    out_t        obs;
    logic [31:0] obs_ret;

    int          sel;
    int          n_checks;
    int          n_pass;
    logic [31:0] exp_ret;
    ent_t        sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned Lat = (g == 0) ? 4 : 1;
        localparam int unsigned En  = (g == 1) ? 0 : 1;
        localparam int unsigned Cw  = (g == 0) ? 4 : ((g == 1) ? 32 : 8);
        logic          pc_wr;
        logic          ir_wr;
        logic          wr_en;
        logic          mem_rd;
        logic          mem_wr;
        logic          hilo_wr;
        logic [1:0]    sel_dest;
        logic          sel_opB;
        logic [5:0]    alu_op;
        logic [1:0]    sel_data;
        logic [1:0]    sel_pc;
        logic          sel_addr;
        logic [2:0]    state;
        logic          illegal;
        logic [Cw-1:0] retired;

        mc_controller #(
            .MUL_LAT (Lat),
            .EN_MULT (En),
            .CNT_W   (Cw)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .opcode    (opcode),
            .funct     (funct),
            .zero      (zero),
            .mem_ready (mem_ready),
            .pc_wr     (pc_wr),
            .ir_wr     (ir_wr),
            .wr_en     (wr_en),
            .mem_rd    (mem_rd),
            .mem_wr    (mem_wr),
            .hilo_wr   (hilo_wr),
            .sel_dest  (sel_dest),
            .sel_opB   (sel_opB),
            .alu_op    (alu_op),
            .sel_data  (sel_data),
            .sel_pc    (sel_pc),
            .sel_addr  (sel_addr),
            .state     (state),
            .illegal   (illegal),
            .retired   (retired)
        );

        assign o_out[g] = {state, pc_wr, ir_wr, wr_en, mem_rd, mem_wr, hilo_wr, illegal,
                           sel_pc, sel_dest, sel_data, sel_addr, alu_op, sel_opB};
        assign o_ret[g] = 32'(retired);
    end

    always_comb begin
        obs     = o_out[sel];
        obs_ret = o_ret[sel];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int s);
        return (s == 0) ? 4 : 1;
    endfunction

    function automatic bit en_of(input int s);
        return s != 1;
    endfunction

    function automatic logic [31:0] mask_of(input int s);
        int cw;
        cw = (s == 0) ? 4 : ((s == 1) ? 32 : 8);
        return (cw == 32) ? 32'hffff_ffff : ((32'd1 << cw) - 32'd1);
    endfunction

    function automatic out_t mk(input logic [2:0] st, input logic [6:0] stb,
                                input logic [1:0] pc, input logic [1:0] dst,
                                input logic [1:0] dat, input logic addr,
                                input logic [5:0] alu, input logic opb);
        out_t o;
        o.st   = st;
        o.stb  = stb;
        o.pc   = pc;
        o.dst  = dst;
        o.dat  = dat;
        o.addr = addr;
        o.alu  = alu;
        o.opb  = opb;
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push(input logic mr, input out_t o);
        ent_t e;
        e.mr = mr;
        e.o  = o;
        sb.push_back(e);
    endtask

    // Reference model: expected per-cycle outputs of one instruction
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int fwait, input int mwait);
        bit         r;
        bit         r_alu;
        bit         r_jr;
        bit         r_mul;
        bit         ok;
        logic [5:0] alu;
        logic       opb;
        int         lat;
        lat   = lat_of(sel);
        r     = (op == 6'h00);
        r_alu = r && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a || fn == 6'h00 || fn == 6'h02);
        r_jr  = r && (fn == 6'h08);
        r_mul = r && (fn == 6'h18) && en_of(sel);
        ok    = r_alu || r_jr || r_mul || op == 6'h08 || op == 6'h0a || op == 6'h23 ||
                op == 6'h2b || op == 6'h04 || op == 6'h05 || op == 6'h02 || op == 6'h03;
        alu   = r ? fn : ((op == 6'h0a) ? 6'h2a : ((op == 6'h04 || op == 6'h05) ? op : 6'h20));
        opb   = (op == 6'h08 || op == 6'h0a || op == 6'h23 || op == 6'h2b);

        for (int i = 0; i < fwait; i++) push(1'b0, mk(3'd0, 7'b0001000, 0, 0, 0, 0, 0, 0));
        push(1'b1, mk(3'd0, 7'b1101000, 0, 0, 0, 0, 0, 0));
        if (!ok) begin
            push(1'b1, mk(3'd1, 7'b0000001, 0, 0, 0, 0, 0, 0));
        end else if (op == 6'h02) begin
            push(1'b1, mk(3'd1, 7'b1000000, 2, 0, 0, 0, 0, 0));
        end else if (op == 6'h03) begin
            push(1'b1, mk(3'd1, 7'b1010000, 2, 2, 2, 0, 0, 0));
        end else begin
            push(1'b1, mk(3'd1, 7'b0000000, 0, 0, 0, 0, 0, 0));
            if (r_alu || op == 6'h08 || op == 6'h0a) begin
                push(1'b1, mk(3'd2, 7'b0000000, 0, 0, 0, 0, alu, opb));
                push(1'b1, mk(3'd4, 7'b0010000, 0, r ? 2'd0 : 2'd1, 0, 0, 0, 0));
            end else if (op == 6'h23 || op == 6'h2b) begin
                push(1'b1, mk(3'd2, 7'b0000000, 0, 0, 0, 0, alu, opb));
                for (int i = 0; i < mwait; i++)
                    push(1'b0, mk(3'd3, (op == 6'h23) ? 7'b0001000 : 7'b0000100,
                                  0, 0, 0, 1, 0, 0));
                push(1'b1, mk(3'd3, (op == 6'h23) ? 7'b0001000 : 7'b0000100, 0, 0, 0, 1, 0, 0));
                if (op == 6'h23) push(1'b1, mk(3'd4, 7'b0010000, 0, 1, 1, 0, 0, 0));
            end else if (op == 6'h04 || op == 6'h05) begin
                push(1'b1, mk(3'd2, {(op == 6'h04) ? z : ~z, 6'b0}, 1, 0, 0, 0, alu, 0));
            end else if (r_jr) begin
                push(1'b1, mk(3'd2, 7'b1000000, 3, 0, 0, 0, alu, 0));
            end else begin
                push(1'b1, mk(3'd2, 7'b0000000, 0, 0, 0, 0, 6'h18, 0));
                for (int k = 0; k < lat; k++)
                    push(1'b1, mk(3'd5, (k == lat - 1) ? 7'b0000010 : 7'b0000000,
                                  0, 0, 0, 0, 6'h18, 0));
            end
        end
        if (ok) exp_ret = (exp_ret + 32'd1) & mask_of(sel);
    endtask

    // Drain the scoreboard: drive each cycle's mem_ready, compare on the falling edge
    task automatic run_sb(input string nm, input bit chk_ret);
        ent_t e;
        int   idx;
        idx = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr;
            @(negedge clk);
            check_eq($sformatf("%s cyc%0d", nm, idx), {8'h0, obs}, {8'h0, e.o});
            @(posedge clk);
            #1;
            idx++;
        end
        if (chk_ret) check_eq({nm, " retired"}, obs_ret, exp_ret);
    endtask

    task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fwait, input int mwait);
        opcode = op;
        funct  = fn;
        zero   = z;
        push_instr(op, fn, z, fwait, mwait);
        run_sb(nm, 1'b1);
    endtask

    // Assert reset off the clock edge, hold it across an edge, release it into FETCH
    task automatic do_reset(input string nm);
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_eq({nm, " rst outs"}, {8'h0, obs}, 32'h0);
        check_eq({nm, " rst retired"}, obs_ret, 32'h0);
        exp_ret = 32'h0;
        @(posedge clk);
        #1;
        check_eq({nm, " rst held outs"}, {8'h0, obs}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq({nm, " post-rst fetch"}, {8'h0, obs},
                 {8'h0, mk(3'd0, 7'b0001000, 0, 0, 0, 0, 0, 0)});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        exp_ret   = 32'h0;
        sel       = 0;
        rst       = 1'b1;
        opcode    = 6'h00;
        funct     = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Instance 0: MUL_LAT=4, EN_MULT=1, CNT_W=4
        sel = 0;
        do_reset("A");
        do_instr("add",           6'h00, 6'h20, 1'b0, 0, 0);
        do_instr("lw wait3",      6'h23, 6'h00, 1'b0, 0, 3);
        do_instr("sw fwait2",     6'h2b, 6'h00, 1'b0, 2, 1);
        do_instr("beq z0",        6'h04, 6'h00, 1'b0, 0, 0);
        do_instr("bne z0",        6'h05, 6'h00, 1'b0, 0, 0);
        do_instr("beq z1",        6'h04, 6'h00, 1'b1, 0, 0);
        do_instr("bne z1",        6'h05, 6'h00, 1'b1, 0, 0);
        do_instr("jr",            6'h00, 6'h08, 1'b0, 0, 0);
        do_instr("j",             6'h02, 6'h00, 1'b0, 0, 0);
        do_instr("jal",           6'h03, 6'h00, 1'b0, 0, 0);
        do_instr("addi",          6'h08, 6'h00, 1'b0, 0, 0);
        do_instr("slti",          6'h0a, 6'h00, 1'b0, 0, 0);
        do_instr("sub",           6'h00, 6'h22, 1'b0, 0, 0);
        do_instr("slt",           6'h00, 6'h2a, 1'b0, 0, 0);
        do_instr("sll",           6'h00, 6'h00, 1'b0, 0, 0);
        do_instr("srl",           6'h00, 6'h02, 1'b0, 0, 0);
        do_instr("illegal op",    6'h3f, 6'h00, 1'b0, 0, 0);
        do_instr("illegal funct", 6'h00, 6'h3f, 1'b0, 0, 0);
        do_instr("mult lat4",     6'h00, 6'h18, 1'b0, 0, 0);

        // SW aborted by reset during its memory wait
        opcode = 6'h2b;
        funct  = 6'h00;
        zero   = 1'b0;
        push_instr(6'h2b, 6'h00, 1'b0, 0, 3);
        void'(sb.pop_back());
        run_sb("sw abort", 1'b0);
        #2;
        check_eq("sw pre-abort", {8'h0, obs}, {8'h0, mk(3'd3, 7'b0000100, 0, 0, 0, 1, 0, 0)});
        do_reset("sw abort");

        // Counter wrap at CNT_W=4
        for (int i = 0; i < 16; i++) do_instr($sformatf("wrap add%0d", i), 6'h00, 6'h20, 1'b0, 0, 0);

        // Instance 1: EN_MULT=0
        sel = 1;
        do_reset("B");
        do_instr("mult disabled", 6'h00, 6'h18, 1'b0, 0, 0);
        do_instr("add B",         6'h00, 6'h20, 1'b0, 0, 0);

        // Instance 2: MUL_LAT=1
        sel = 2;
        do_reset("C");
        do_instr("mult lat1",     6'h00, 6'h18, 1'b0, 0, 0);
        do_instr("lw C",          6'h23, 6'h00, 1'b0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
